cellram_arbiter: RTL and testbench

//  Shares one CellRAM burst controller between two requesters (port 0, port 1).

---
 rtl/cellram_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_cellram_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cellram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : cellram_arbiter
//  Description : Two-port arbiter in front of a single CellRAM burst-mode
//                controller. Grants one requester, latches its command,
//                pulses MemCE, waits for MemDone (with a watchdog) and
//                acknowledges the owner with read data and an error flag.
//  Options     : ROUND_ROBIN_EN - when defined, ties alternate between the
//                ports; otherwise port 0 always wins a tie.
//  Revision    : 1.0 - initial release
// ============================================================================
module cellram_arbiter #(
  parameter int ADDR_W  = 20,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 64
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req0,
  input  logic              i_req1,
  input  logic              i_write0,
  input  logic              i_write1,
  input  logic [ADDR_W-1:0] i_addr0,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic [DATA_W-1:0] i_wdata0,
  input  logic [DATA_W-1:0] i_wdata1,
  output logic              o_ack0,
  output logic              o_ack1,
  output logic [DATA_W-1:0] o_rdata0,
  output logic [DATA_W-1:0] o_rdata1,
  output logic              o_err0,
  output logic              o_err1,
  output logic              o_mem_ce,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_address,
  output logic [DATA_W-1:0] o_mem_data_out,
  input  logic [DATA_W-1:0] i_mem_data_in,
  input  logic              i_mem_done,
  input  logic              i_mem_yield,
  output logic              o_owner,
  output logic              o_busy
);

  // Timer is wide enough to hold TIMEOUT itself, so it can never wrap.
  localparam int               c_TMR_W    = $clog2(TIMEOUT) + 1;
  localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ISSUE    = 2'd1,
    S_WAIT     = 2'd2,
    S_COMPLETE = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                w_grant;
  logic                w_timeout;
  logic                w_winner;
  logic                w_complete;

  logic                r_owner;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [c_TMR_W-1:0]  r_timer;
  logic                r_err;
  logic [DATA_W-1:0]   r_rdata0;
  logic [DATA_W-1:0]   r_rdata1;

`ifdef ROUND_ROBIN_EN
  // Port served by the most recent grant; reset value makes port 0 win the first tie.
  logic                r_last;

  // Tie goes to the port not served last; a lone requester simply wins.
  always_comb begin
    w_winner = ~i_req0;
    if (i_req0 && i_req1) begin
      w_winner = ~r_last;
    end
  end

  // Remember the winner of every grant, single-requester grants included.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_last <= 1'b1;
    end else if (w_grant) begin
      r_last <= w_winner;
    end
  end
`else
  // Fixed priority: port 0 wins whenever it is requesting.
  always_comb begin
    w_winner = ~i_req0;
  end
`endif

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic: grant from IDLE, one ISSUE cycle, WAIT for done or watchdog.
  always_comb begin
    w_next    = r_state;
    w_grant   = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!i_mem_yield && (i_req0 || i_req1)) begin
          w_grant = 1'b1;
          w_next  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_next = S_WAIT;
      end
      S_WAIT: begin
        // MemDone takes precedence over a coincident expiry.
        if (i_mem_done) begin
          w_next = S_COMPLETE;
        end else if (r_timer == c_TMR_LAST) begin
          w_timeout = 1'b1;
          w_next    = S_COMPLETE;
        end
      end
      S_COMPLETE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Command latch, watchdog timer, error flag and per-port read data.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_owner  <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_timer  <= '0;
      r_err    <= 1'b0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      if (w_grant) begin
        r_owner <= w_winner;
        r_we    <= w_winner ? i_write1 : i_write0;
        r_addr  <= w_winner ? i_addr1  : i_addr0;
        r_wdata <= w_winner ? i_wdata1 : i_wdata0;
        r_err   <= 1'b0;
      end
      if (r_state == S_ISSUE) begin
        r_timer <= '0;
      end else if (r_state == S_WAIT && r_timer != c_TMR_LAST) begin
        r_timer <= r_timer + c_TMR_W'(1);
      end
      if (w_timeout) begin
        r_err <= 1'b1;
      end
      if (r_state == S_WAIT && i_mem_done && !r_we) begin
        if (r_owner) begin
          r_rdata1 <= i_mem_data_in;
        end else begin
          r_rdata0 <= i_mem_data_in;
        end
      end
    end
  end

  assign w_complete     = (r_state == S_COMPLETE);
  assign o_ack0         = w_complete && !r_owner;
  assign o_ack1         = w_complete &&  r_owner;
  assign o_err0         = o_ack0 && r_err;
  assign o_err1         = o_ack1 && r_err;
  assign o_rdata0       = r_rdata0;
  assign o_rdata1       = r_rdata1;
  assign o_mem_ce       = (r_state == S_ISSUE);
  assign o_mem_we       = r_we;
  assign o_mem_address  = r_addr;
  assign o_mem_data_out = r_wdata;
  assign o_owner        = r_owner;
  assign o_busy         = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_cellram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cellram_arbiter
//  Description : Directed bench for cellram_arbiter. A cycle-numbered access
//                model predicts every output; a small controller stand-in
//                answers MemCE after a programmable delay.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cellram_arbiter;
  localparam int ADDR_W  = 20;
  localparam int DATA_W  = 16;
  localparam int TIMEOUT = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, req0, req1, write0, write1, done, yield;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1, din;
  logic              o_ack0, o_ack1, o_err0, o_err1, o_mem_ce, o_mem_we, o_owner, o_busy;
  logic [DATA_W-1:0] o_rdata0, o_rdata1, o_mem_data_out;
  logic [ADDR_W-1:0] o_mem_address;

  cellram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_req0(req0), .i_req1(req1), .i_write0(write0), .i_write1(write1),
    .i_addr0(addr0), .i_addr1(addr1), .i_wdata0(wdata0), .i_wdata1(wdata1),
    .o_ack0(o_ack0), .o_ack1(o_ack1), .o_rdata0(o_rdata0), .o_rdata1(o_rdata1),
    .o_err0(o_err0), .o_err1(o_err1), .o_mem_ce(o_mem_ce), .o_mem_we(o_mem_we),
    .o_mem_address(o_mem_address), .o_mem_data_out(o_mem_data_out),
    .i_mem_data_in(din), .i_mem_done(done), .i_mem_yield(yield),
    .o_owner(o_owner), .o_busy(o_busy)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- access model (cycle-number arithmetic) ----------------
  bit              m_busy = 0, m_port = 0, m_we = 0, m_err = 0, m_last = 1, win;
  int              m_ce = -1, m_ack = -1;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [DATA_W-1:0] m_wdata = '0;
  logic [DATA_W-1:0] m_rdata [2];

  initial begin
    m_rdata[0] = '0;
    m_rdata[1] = '0;
  end

  // At each edge: inputs seen belong to cycle cyc-1, state computed is for cycle cyc.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      m_busy = 0; m_port = 0; m_we = 0; m_err = 0; m_last = 1;
      m_addr = '0; m_wdata = '0; m_rdata[0] = '0; m_rdata[1] = '0;
      m_ce = -1; m_ack = -1;
    end else if (m_busy) begin
      if (m_ack >= 0) begin
        if (cyc - 1 == m_ack) m_busy = 0;
      end else if (cyc - 1 > m_ce) begin
        if (done) begin
          m_ack = cyc; m_err = 0;
          if (!m_we) m_rdata[m_port] = din;
        end else if (cyc - 1 - m_ce == TIMEOUT) begin
          m_ack = cyc; m_err = 1;
        end
      end
    end else if (!yield && (req0 || req1)) begin
`ifdef ROUND_ROBIN_EN
      win = (req0 && req1) ? !m_last : !req0;
`else
      win = !req0;
`endif
      m_last = win;
      m_busy = 1; m_port = win; m_ce = cyc; m_ack = -1; m_err = 0;
      m_we    = win ? write1 : write0;
      m_addr  = win ? addr1  : addr0;
      m_wdata = win ? wdata1 : wdata0;
    end
  end

  // ---------------- controller stand-in ----------------
  int ce_cyc = -1000;
  int done_delay = 0;
  logic [DATA_W-1:0] mem_rdata = '0;

  always @(posedge clk) begin
    #2;
    if (done_delay > 0 && cyc == ce_cyc + done_delay) begin
      done = 1'b1; din = mem_rdata;
    end else begin
      done = 1'b0; din = 16'hDEAD;
    end
  end

  // ---------------- compare + event monitor ----------------
  int ce_count = 0, ack_count = 0;
  logic              ce_we;
  logic [ADDR_W-1:0] ce_addr;
  bit                grants [$];
  bit                e_ce, e_ack0, e_ack1;

  always @(negedge clk) begin
    e_ce   = m_busy && cyc == m_ce;
    e_ack0 = m_busy && cyc == m_ack && !m_port;
    e_ack1 = m_busy && cyc == m_ack &&  m_port;
    chk("busy",     o_busy,         m_busy);
    chk("mem_ce",   o_mem_ce,       e_ce);
    chk("ack0",     o_ack0,         e_ack0);
    chk("ack1",     o_ack1,         e_ack1);
    chk("err0",     o_err0,         e_ack0 && m_err);
    chk("err1",     o_err1,         e_ack1 && m_err);
    chk("owner",    o_owner,        m_port);
    chk("mem_we",   o_mem_we,       m_we);
    chk("mem_addr", o_mem_address,  m_addr);
    chk("mem_dout", o_mem_data_out, m_wdata);
    chk("rdata0",   o_rdata0,       m_rdata[0]);
    chk("rdata1",   o_rdata1,       m_rdata[1]);
    if (o_mem_ce) begin
      ce_cyc = cyc; ce_count++; ce_we = o_mem_we; ce_addr = o_mem_address;
      grants.push_back(o_owner);
    end
    if (o_ack0 || o_ack1) ack_count++;
  end

  // ---------------- stimulus helpers ----------------
  int a_cyc;
  bit a_err, a_port;
  logic [DATA_W-1:0] a_r0, a_r1, a_dout;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_ack(input int limit);
    bit found = 0;
    for (int i = 0; i < limit && !found; i++) begin
      @(negedge clk);
      if (o_ack0 || o_ack1) begin
        found = 1; a_cyc = cyc; a_err = o_err0 | o_err1; a_port = o_ack1;
        a_r0 = o_rdata0; a_r1 = o_rdata1; a_dout = o_mem_data_out;
      end
    end
    chk("wait_ack_bound", found, 1'b1);
  endtask

  task automatic wait_ce(input int limit);
    bit found = 0;
    for (int i = 0; i < limit && !found; i++) begin
      @(negedge clk);
      if (o_mem_ce) found = 1;
    end
    chk("wait_ce_bound", found, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  // ---------------- directed tests ----------------
  int t, n0;
  bit exp_order [4];

  initial begin
    rst = 1; req0 = 0; req1 = 0; write0 = 0; write1 = 0; yield = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; done = 0; din = '0;
    repeat (3) tick();
    chk("reset_busy", o_busy, 1'b0);
    chk("reset_ce", o_mem_ce, 1'b0);
    rst = 0;
    tick();

    // 1: read on port 0
    done_delay = 5; mem_rdata = 16'hBEEF;
    addr0 = 20'h00010; write0 = 0; req0 = 1; t = cyc;
    wait_ack(100);
    chk("t1_ce_latency", ce_cyc - t, 1);
    chk("t1_ce_we", ce_we, 1'b0);
    chk("t1_ack_latency", a_cyc - ce_cyc, 6);
    chk("t1_rdata0", a_r0, 16'hBEEF);
    chk("t1_err", a_err, 1'b0);
    chk("t1_port", a_port, 1'b0);
    tick(); req0 = 0;
    repeat (2) tick();

    // 2: write on port 1, inputs change after grant
    done_delay = 3; mem_rdata = 16'h5555;
    addr1 = 20'hFFFFF; wdata1 = 16'h1234; write1 = 1; req1 = 1;
    wait_ce(20);
    tick(); addr1 = 20'h00000; wdata1 = 16'hFFFF; write1 = 0;
    wait_ack(100);
    chk("t2_ce_we", ce_we, 1'b1);
    chk("t2_ce_addr", ce_addr, 20'hFFFFF);
    chk("t2_dout_held", a_dout, 16'h1234);
    chk("t2_rdata1", a_r1, 16'h0000);
    chk("t2_port", a_port, 1'b1);
    chk("t2_ack_latency", a_cyc - ce_cyc, 4);
    tick(); req1 = 0;
    repeat (2) tick();

    // 3: tie held for four accesses
    grants.delete();
    done_delay = 2; write0 = 0; write1 = 0; req0 = 1; req1 = 1;
    repeat (4) wait_ack(100);
    tick(); req0 = 0; req1 = 0;
`ifdef ROUND_ROBIN_EN
    exp_order = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_order = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    chk("t3_grant_count", grants.size(), 4);
    for (int i = 0; i < 4 && i < grants.size(); i++) chk("t3_grant_order", grants[i], exp_order[i]);
    repeat (2) tick();

    // 4: timeout, controller never answers
    done_delay = 0; req0 = 1;
    wait_ack(300);
    chk("t4_ack_latency", a_cyc - ce_cyc, 65);
    chk("t4_err", a_err, 1'b1);
    chk("t4_port", a_port, 1'b0);
    tick(); req0 = 0;
    @(negedge clk);
    chk("t4_idle_after", o_busy, 1'b0);
    tick();

    // 5: yield blocks grants
    done_delay = 4; mem_rdata = 16'hA5A5;
    yield = 1; req0 = 1; n0 = ce_count;
    repeat (10) tick();
    chk("t5_no_ce", ce_count - n0, 0);
    yield = 0; t = cyc;
    wait_ack(100);
    chk("t5_ce_latency", ce_cyc - t, 1);
    chk("t5_rdata0", a_r0, 16'hA5A5);
    tick(); req0 = 0;
    repeat (2) tick();

    // 6: reset during WAIT
    done_delay = 0; req0 = 1;
    wait_ce(20);
    tick(); tick();
    rst = 1; req0 = 0; n0 = ack_count;
    @(negedge clk);
    @(negedge clk);
    chk("t6_busy", o_busy, 1'b0);
    chk("t6_ce", o_mem_ce, 1'b0);
    chk("t6_rdata0", o_rdata0, 16'h0000);
    chk("t6_ack0", o_ack0, 1'b0);
    tick(); rst = 0;
    repeat (5) tick();
    chk("t6_no_ack", ack_count - n0, 0);

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
